// File: rtl/mips_ctrl_pkg.sv
// Shared constants for the multi-cycle MIPS control path: ALU operation codes,
// opcode/funct values, state encoding and a terminal-state helper.
package mips_ctrl_pkg;

   typedef enum logic [3:0] {
      ALU_AND = 4'b0000,
      ALU_OR  = 4'b0001,
      ALU_NOR = 4'b0010,
      ALU_ADD = 4'b0011,
      ALU_SUB = 4'b0100,
      ALU_LUI = 4'b0101,
      ALU_SLL = 4'b0111,
      ALU_SRL = 4'b1000,
      ALU_BNE = 4'b1001,
      ALU_BEQ = 4'b1111
   } alu_op_e;

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMRD    = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWR    = 4'd5,
      S_RTYPE_EX = 4'd6,
      S_RTYPE_WB = 4'd7,
      S_BRANCH   = 4'd8,
      S_JUMP     = 4'd9,
      S_ITYPE_EX = 4'd10,
      S_ITYPE_WB = 4'd11
   } state_e;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_ANDI  = 6'h0C;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_LUI   = 6'h0F;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   localparam logic [5:0] FN_SLL = 6'h00;
   localparam logic [5:0] FN_SRL = 6'h02;
   localparam logic [5:0] FN_ADD = 6'h20;
   localparam logic [5:0] FN_SUB = 6'h22;
   localparam logic [5:0] FN_AND = 6'h24;
   localparam logic [5:0] FN_OR  = 6'h25;
   localparam logic [5:0] FN_NOR = 6'h27;

   // States whose exit to FETCH retires an instruction.
   function automatic logic is_terminal(input state_e s);
      return (s == S_RTYPE_WB) || (s == S_MEMWB) || (s == S_MEMWR) ||
             (s == S_BRANCH)   || (s == S_JUMP)  || (s == S_ITYPE_WB);
   endfunction

endpackage

// File: rtl/alu_op_decoder.sv
// Combinational ALU operation select from control state and IR fields.
// Flags an unsupported R-type funct so the FSM can abort the instruction.
module alu_op_decoder
   import mips_ctrl_pkg::*;
(
   input  state_e      state,
   input  logic [5:0]  opcode,
   input  logic [5:0]  funct,
   output logic [3:0]  alu_op,
   output logic        illegal_funct
);

   // ADD is the idle/address op; R-type op stays valid through writeback.
   always_comb begin
      alu_op        = ALU_ADD;
      illegal_funct = 1'b0;
      case (state)
         S_RTYPE_EX, S_RTYPE_WB: begin
            case (funct)
               FN_ADD:  alu_op = ALU_ADD;
               FN_SUB:  alu_op = ALU_SUB;
               FN_AND:  alu_op = ALU_AND;
               FN_OR:   alu_op = ALU_OR;
               FN_NOR:  alu_op = ALU_NOR;
               FN_SLL:  alu_op = ALU_SLL;
               FN_SRL:  alu_op = ALU_SRL;
               default: illegal_funct = 1'b1;
            endcase
         end
         S_ITYPE_EX: begin
            case (opcode)
               OP_ANDI: alu_op = ALU_AND;
               OP_ORI:  alu_op = ALU_OR;
               OP_LUI:  alu_op = ALU_LUI;
               default: alu_op = ALU_ADD;
            endcase
         end
         S_BRANCH: alu_op = (opcode == OP_BNE) ? ALU_BNE : ALU_BEQ;
         default: ;
      endcase
   end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multi-cycle MIPS main control FSM. Moore outputs decoded from the state
// register; PCEn additionally follows Zero for branches. While reset is high
// every enable is forced low so an aborted access never writes.
// Optional retired-instruction counter: define MULTICYCLE_INSTR_COUNT_EN.
module multicycle_control_unit
   import mips_ctrl_pkg::*;
#(
   parameter int WAIT_MEM    = 1,
   parameter int COUNT_WIDTH = 32
)(
   input  logic                   clk,
   input  logic                   reset,
   input  logic [5:0]             Opcode,
   input  logic [5:0]             Funct,
   input  logic                   Zero,
   input  logic                   MemReady,
   output logic [3:0]             ALUOperation,
   output logic                   ALUSrcA,
   output logic [1:0]             ALUSrcB,
   output logic                   IorD,
   output logic                   MemRead,
   output logic                   MemWrite,
   output logic                   IRWrite,
   output logic                   RegWrite,
   output logic                   RegDst,
   output logic                   MemtoReg,
   output logic                   PCEn,
   output logic [1:0]             PCSource,
   output logic                   IllegalOp,
   output logic [COUNT_WIDTH-1:0] InstrCount
);

   state_e     state, state_nxt;
   logic [3:0] dec_op;
   logic       dec_ill;
   logic       pcwrite, branch;
   logic       mem_ok;

   assign mem_ok = (WAIT_MEM == 0) || MemReady;

   alu_op_decoder u_alu_dec (
      .state         (state),
      .opcode        (Opcode),
      .funct         (Funct),
      .alu_op        (dec_op),
      .illegal_funct (dec_ill)
   );

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= S_FETCH;
      else       state <= state_nxt;
   end

   // Next-state and Moore output decode; reset masks everything to idle.
   always_comb begin
      state_nxt    = state;
      ALUOperation = dec_op;
      ALUSrcA      = 1'b0;
      ALUSrcB      = 2'b00;
      IorD         = 1'b0;
      MemRead      = 1'b0;
      MemWrite     = 1'b0;
      IRWrite      = 1'b0;
      RegWrite     = 1'b0;
      RegDst       = 1'b0;
      MemtoReg     = 1'b0;
      PCSource     = 2'b00;
      IllegalOp    = 1'b0;
      pcwrite      = 1'b0;
      branch       = 1'b0;
      case (state)
         S_FETCH: begin
            MemRead = 1'b1;
            ALUSrcB = 2'b01;
            if (mem_ok) begin
               IRWrite   = 1'b1;
               pcwrite   = 1'b1;
               state_nxt = S_DECODE;
            end
         end
         S_DECODE: begin
            ALUSrcB = 2'b11;
            case (Opcode)
               OP_RTYPE:                        state_nxt = S_RTYPE_EX;
               OP_LW, OP_SW:                    state_nxt = S_MEMADR;
               OP_BEQ, OP_BNE:                  state_nxt = S_BRANCH;
               OP_J:                            state_nxt = S_JUMP;
               OP_ADDI, OP_ANDI, OP_ORI, OP_LUI: state_nxt = S_ITYPE_EX;
               default: begin
                  IllegalOp = 1'b1;
                  state_nxt = S_FETCH;
               end
            endcase
         end
         S_MEMADR: begin
            ALUSrcA   = 1'b1;
            ALUSrcB   = 2'b10;
            state_nxt = (Opcode == OP_LW) ? S_MEMRD : S_MEMWR;
         end
         S_MEMRD: begin
            MemRead = 1'b1;
            IorD    = 1'b1;
            if (mem_ok) state_nxt = S_MEMWB;
         end
         S_MEMWB: begin
            RegWrite  = 1'b1;
            MemtoReg  = 1'b1;
            state_nxt = S_FETCH;
         end
         S_MEMWR: begin
            MemWrite = 1'b1;
            IorD     = 1'b1;
            if (mem_ok) state_nxt = S_FETCH;
         end
         S_RTYPE_EX: begin
            ALUSrcA = 1'b1;
            if (dec_ill) begin
               IllegalOp = 1'b1;
               state_nxt = S_FETCH;
            end else begin
               state_nxt = S_RTYPE_WB;
            end
         end
         S_RTYPE_WB: begin
            RegWrite  = 1'b1;
            RegDst    = 1'b1;
            state_nxt = S_FETCH;
         end
         S_BRANCH: begin
            ALUSrcA   = 1'b1;
            PCSource  = 2'b01;
            branch    = 1'b1;
            state_nxt = S_FETCH;
         end
         S_JUMP: begin
            pcwrite   = 1'b1;
            PCSource  = 2'b10;
            state_nxt = S_FETCH;
         end
         S_ITYPE_EX: begin
            ALUSrcA   = 1'b1;
            ALUSrcB   = 2'b10;
            state_nxt = S_ITYPE_WB;
         end
         S_ITYPE_WB: begin
            RegWrite  = 1'b1;
            state_nxt = S_FETCH;
         end
         default: state_nxt = S_FETCH;
      endcase
      PCEn = pcwrite | (branch & Zero);
      if (reset) begin
         ALUOperation = ALU_ADD;
         ALUSrcA      = 1'b0;
         ALUSrcB      = 2'b00;
         IorD         = 1'b0;
         MemRead      = 1'b0;
         MemWrite     = 1'b0;
         IRWrite      = 1'b0;
         RegWrite     = 1'b0;
         RegDst       = 1'b0;
         MemtoReg     = 1'b0;
         PCSource     = 2'b00;
         IllegalOp    = 1'b0;
         PCEn         = 1'b0;
      end
   end

`ifdef MULTICYCLE_INSTR_COUNT_EN
   logic                   retire;
   logic [COUNT_WIDTH-1:0] instr_cnt;

   assign retire = is_terminal(state) && (state_nxt == S_FETCH);

   // Retired-instruction counter; wraps naturally at 2^COUNT_WIDTH.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)       instr_cnt <= '0;
      else if (retire) instr_cnt <= instr_cnt + COUNT_WIDTH'(1);
   end

   assign InstrCount = instr_cnt;
`else
   assign InstrCount = '0;
`endif

endmodule

// File: doc/multicycle_control_unit.md
Name: multicycle_control_unit

Overview:
- Multi-cycle MIPS main control FSM; the producing end of the ALU's ALUOperation/Zero interface.
- Sequences each instruction through fetch, decode, execute, memory and writeback states.
- Drives datapath muxes, register/memory enables and the 4-bit ALU operation code.
- Consumes the ALU branch-condition output Zero to gate branch PC updates.

Parameters:
- WAIT_MEM, 1: 1 = FETCH/MEMRD/MEMWR hold until MemReady=1; 0 = MemReady ignored, one cycle each.
- COUNT_WIDTH, 32: width of the optional retired-instruction counter.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- Opcode  in  6  IR[31:26], valid from DECODE onward.
- Funct  in  6  IR[5:0].
- Zero  in  1  ALU branch condition, 1 = taken; valid in BRANCH.
- MemReady  in  1  memory done for the current access.
- ALUOperation  out  4  AND=0000 OR=0001 NOR=0010 ADD=0011 SUB=0100 LUI=0101 SLL=0111 SRL=1000 BNE=1001 BEQ=1111.
- ALUSrcA  out  1  0 = PC, 1 = reg A.
- ALUSrcB  out  2  00 = reg B, 01 = const 4, 10 = sign-ext imm, 11 = sign-ext imm<<2.
- IorD, MemRead, MemWrite, IRWrite  out  1 each  memory/IR control.
- RegWrite, RegDst, MemtoReg  out  1 each  register-file control.
- PCEn  out  1  PC load = PCWrite | (Branch & Zero).
- PCSource  out  2  00 = ALU, 01 = ALUOut, 10 = jump target.
- IllegalOp  out  1  one-cycle pulse on an unsupported opcode/funct.
- InstrCount  out  COUNT_WIDTH  retired-instruction count (optional feature).

Behaviour:
- Reset: state=FETCH; all enables 0; ALUOperation=ADD; muxes 0; IllegalOp=0. Reset mid-instruction aborts it with no writes.
- Outputs are Moore, decoded from a registered state. PCEn is the only output that also depends on Zero.
- FETCH: MemRead, IRWrite, ALUSrcB=01, ADD, PCWrite.
  - When WAIT_MEM=1 and MemReady=0: stay in FETCH with IRWrite and PCWrite masked.
  - Advance to DECODE on the ready cycle.
- DECODE: ALUSrcB=11, ADD (branch target into ALUOut). Next state by Opcode:
  - 0x00 R-type -> RTYPE_EX.
  - 0x23 lw, 0x2B sw -> MEMADR.
  - 0x04 beq, 0x05 bne -> BRANCH.
  - 0x02 j -> JUMP.
  - 0x08 addi, 0x0C andi, 0x0D ori, 0x0F lui -> ITYPE_EX.
  - Any other opcode -> FETCH, IllegalOp pulse.
- RTYPE_EX: ALUSrcA=1, ALUSrcB=00. Funct mapping:
  - 0x20 ADD, 0x22 SUB, 0x24 AND, 0x25 OR, 0x27 NOR, 0x00 SLL, 0x02 SRL.
  - Unknown funct -> FETCH, IllegalOp pulse, no writeback.
  - Next state RTYPE_WB.
- RTYPE_WB: RegWrite, RegDst=1, MemtoReg=0; ALUOperation held from RTYPE_EX.
- MEMADR: ALUSrcA=1, ALUSrcB=10, ADD. Next MEMRD (lw) or MEMWR (sw).
- MEMRD: MemRead, IorD=1; waits for MemReady; next MEMWB.
- MEMWB: RegWrite, MemtoReg=1, RegDst=0.
- MEMWR: MemWrite, IorD=1; MemWrite held until MemReady.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOperation=BEQ or BNE, PCSource=01, Branch internal; PCEn=Zero.
- JUMP: PCWrite, PCSource=10.
- ITYPE_EX: ALUSrcA=1, ALUSrcB=10; ADD/AND/OR/LUI per opcode.
- ITYPE_WB: RegWrite, RegDst=0, MemtoReg=0.
- All terminal states (RTYPE_WB, MEMWB, MEMWR, BRANCH, JUMP, ITYPE_WB) return to FETCH.
- CPI: R/I-type 4, lw 5, sw 4, branch 3, jump 3 (at MemReady=1).

Optional Feature:
- MULTICYCLE_INSTR_COUNT_EN defined: InstrCount increments on every exit from a terminal state to FETCH. It does not count illegal instructions, is cleared by reset, and wraps at 2^COUNT_WIDTH.
- Undefined: InstrCount tied to 0 and no counter flops are instantiated.

Decomposition:
- Package mips_ctrl_pkg: ALU op codes (values above), opcode/funct constants, 4-bit state encoding.
- Sub-module alu_op_decoder: combinational state/Opcode/Funct -> ALUOperation plus illegal-funct flag.

Test Plan:
- R-type add (Opcode=0x00, Funct=0x20), MemReady=1 -> FETCH, DECODE, RTYPE_EX (ALUOperation=0011), RTYPE_WB (RegWrite=1, RegDst=1), back to FETCH in 4 cycles.
- lw (0x23) with MemReady low 3 cycles in MEMRD -> MemRead/IorD held 3 extra cycles; MEMWB RegWrite=1, MemtoReg=1; 8 cycles total.
- beq (0x04): Zero=1 -> ALUOperation=1111, PCEn=1, PCSource=01. bne (0x05), Zero=0 -> ALUOperation=1001, PCEn=0.
- Opcode=0x3F -> IllegalOp=1 for one cycle, FETCH next, RegWrite/MemWrite never asserted. Same check for Opcode=0x00, Funct=0x3F.
- Assert reset during MEMWR -> state=FETCH immediately, MemWrite=0 asynchronously, InstrCount=0.
- With MULTICYCLE_INSTR_COUNT_EN: run add, lw, sw, beq, j -> InstrCount=5. Undefined: InstrCount stays 0.
